// File: rtl/valid_ready_memory.sv
// Single-port word-addressed RAM with a two-cycle valid/ready handshake.
// A request is executed on the IDLE->ACK edge, and ready_o is high for the whole ACK cycle.
module valid_ready_memory #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  w_r_data_i,
  output logic [WIDTH-1:0]      rdata_o,
  input  logic                  valid_i,
  output logic                  ready_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_ACK  = 1'b1;

  logic             state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             in_range;
  logic [IDX_W-1:0] idx;

  // Addresses at or beyond DEPTH still complete the handshake: writes are dropped and reads return zero.
  assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH + 1)'(DEPTH));
  assign idx      = addr_i[IDX_W-1:0];

  // ready_o is taken directly from the state flop, so it has no combinational path from any input.
  assign ready_o  = (state == S_ACK);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      rdata_o <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            state <= S_ACK;
            if (w_r_data_i) begin
              if (in_range) begin
                mem[idx] <= wdata_i;
              end
            end else begin
              rdata_o <= in_range ? mem[idx] : '0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_valid_ready_memory.sv
// Randomised bench for valid_ready_memory: a full-depth instance and a DEPTH=48 instance share the stimulus.
// Both instances are checked against array models driven only by the transaction rules.
module tb_valid_ready_memory;

  logic        clk;
  logic        rst_n;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic        wr;
  logic        valid;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        ready_a;
  logic        ready_b;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [15:0] m64 [64];
  logic [15:0] m48 [48];
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  int unsigned pulses;
  int unsigned hi_cycles;
  logic        prev_ready;

  valid_ready_memory #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .wdata_i(wdata),
    .w_r_data_i(wr), .rdata_o(rdata_a), .valid_i(valid), .ready_o(ready_a)
  );

  valid_ready_memory #(.WIDTH(16), .DEPTH(48), .ADDR_WIDTH(6)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .wdata_i(wdata),
    .w_r_data_i(wr), .rdata_o(rdata_b), .valid_i(valid), .ready_o(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count ready pulses and total high cycles of the full-depth instance; equal counts mean every pulse was one cycle wide.
  always @(negedge clk) begin
    if (ready_a) begin
      hi_cycles++;
      if (!prev_ready) pulses++;
    end
    prev_ready = ready_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 64; i++) m64[i] = '0;
    for (int i = 0; i < 48; i++) m48[i] = '0;
    exp_a = '0;
    exp_b = '0;
  endtask

  task automatic model_apply(input logic w, input logic [5:0] a, input logic [15:0] d);
    if (w) begin
      m64[a] = d;
      if (a < 48) m48[a] = d;
    end else begin
      exp_a = m64[a];
      exp_b = (a < 48) ? m48[a] : 16'h0000;
    end
  endtask

  // One full handshake: present the request, check the ACK cycle, scramble the ignored inputs, check the return to IDLE.
  task automatic txn(input logic w, input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    valid = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    model_apply(w, a, d);
    check("ack_ready_a", 32'(ready_a), 32'd1);
    check("ack_ready_b", 32'(ready_b), 32'd1);
    check("ack_rdata_a", 32'(rdata_a), 32'(exp_a));
    check("ack_rdata_b", 32'(rdata_b), 32'(exp_b));
    @(negedge clk);
    valid = 1'b0;
    wr    = 1'($urandom);
    addr  = 6'($urandom);
    wdata = 16'($urandom);
    @(posedge clk);
    #1;
    check("idle_ready_a", 32'(ready_a), 32'd0);
    check("idle_rdata_a", 32'(rdata_a), 32'(exp_a));
    check("idle_rdata_b", 32'(rdata_b), 32'(exp_b));
  endtask

  initial begin
    logic [5:0]  a;
    logic [15:0] d;
    logic [5:0]  probe [3];
    int unsigned got_pulses;

    n_checks   = 0;
    n_fail     = 0;
    pulses     = 0;
    hi_cycles  = 0;
    prev_ready = 1'b0;
    rst_n      = 1'b0;
    valid      = 1'b0;
    wr         = 1'b0;
    addr       = '0;
    wdata      = '0;
    clear_models();

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full write then read-back across every address.
    pulses    = 0;
    hi_cycles = 0;
    for (int i = 0; i < 64; i++) txn(1'b1, 6'(i), 16'($urandom));
    for (int i = 0; i < 64; i++) txn(1'b0, 6'(i), 16'h0000);
    @(negedge clk);
    check("full_pulses", pulses, 32'd128);
    check("full_width", hi_cycles, pulses);

    // Read data holds across an intervening write.
    txn(1'b1, 6'd5, 16'hA5A5);
    txn(1'b0, 6'd5, 16'h0000);
    check("hold_rd5", 32'(rdata_a), 32'h0000A5A5);
    txn(1'b1, 6'd6, 16'h1234);
    check("hold_after_wr", 32'(rdata_a), 32'h0000A5A5);
    txn(1'b0, 6'd6, 16'h0000);
    check("hold_rd6", 32'(rdata_a), 32'h00001234);

    // A request held for six edges executes three times, on alternating cycles.
    @(negedge clk);
    valid = 1'b1;
    wr    = 1'b1;
    addr  = 6'd3;
    wdata = 16'h00FF;
    got_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("held_pattern", 32'(ready_a), 32'((c % 2) == 0));
      if (ready_a) got_pulses++;
    end
    check("held_pulses", got_pulses, 32'd3);
    @(negedge clk);
    valid = 1'b0;
    model_apply(1'b1, 6'd3, 16'h00FF);
    txn(1'b0, 6'd3, 16'h0000);
    check("held_rd3", 32'(rdata_a), 32'h000000FF);

    // Out-of-range on the 48-word instance: write dropped, read is zero, in-range words intact.
    txn(1'b1, 6'd50, 16'hBEEF);
    txn(1'b0, 6'd50, 16'h0000);
    check("oor_rd50_b", 32'(rdata_b), 32'd0);
    check("oor_rd50_a", 32'(rdata_a), 32'h0000BEEF);
    for (int i = 0; i < 48; i++) txn(1'b0, 6'(i), 16'h0000);

    // Randomised mix of reads and writes over the whole address space.
    for (int n = 0; n < 200; n++) begin
      a = 6'($urandom);
      d = 16'($urandom);
      txn(1'($urandom_range(0, 1)), a, d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // Reset mid-run with valid asserted, after rdata has been loaded with a known non-zero word.
    txn(1'b1, 6'd9, 16'hC3C3);
    txn(1'b0, 6'd9, 16'h0000);
    @(negedge clk);
    valid = 1'b1;
    wr    = 1'b0;
    addr  = 6'd9;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready_a), 32'd0);
    check("arst_rdata", 32'(rdata_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    clear_models();
    probe[0] = 6'd0;
    probe[1] = 6'd31;
    probe[2] = 6'd63;
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, probe[i], 16'h0000);
      check("arst_clear", 32'(rdata_a), 32'd0);
    end

    // Reset during the ACK cycle of a read.
    txn(1'b1, 6'd12, 16'h5A5A);
    @(negedge clk);
    valid = 1'b1;
    wr    = 1'b0;
    addr  = 6'd12;
    @(posedge clk);
    #1;
    check("mid_ack_ready", 32'(ready_a), 32'd1);
    check("mid_ack_rdata", 32'(rdata_a), 32'h00005A5A);
    @(negedge clk);
    valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready_a), 32'd0);
    check("mid_rst_rdata", 32'(rdata_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_models();
    @(posedge clk);
    #1;
    check("mid_idle_ready", 32'(ready_a), 32'd0);
    txn(1'b0, 6'd12, 16'h0000);
    check("mid_restart_rd", 32'(rdata_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
